// File: rtl/id_fwd_scoreboard.sv
// Decode-stage operand resolver and hazard detector.
// Resolves each read port against the forwarding stages (youngest wins), the same-cycle
// MDU completion and the register file. Tracks in-flight long-latency writers in a
// per-register scoreboard, raises a stall for load-use, RAW-on-MDU and WAW-on-MDU hazards,
// and counts stalled cycles in a saturating counter.
module id_fwd_scoreboard #(
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_RD_PORTS-1:0]            rd_en_i,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]     rd_addr_i,
    input  logic [NUM_RD_PORTS*DATA_W-1:0]     rf_data_i,
    input  logic [NUM_FWD_STAGES-1:0]          fwd_we_i,
    input  logic [NUM_FWD_STAGES-1:0]          fwd_valid_i,
    input  logic [NUM_FWD_STAGES*ADDR_W-1:0]   fwd_waddr_i,
    input  logic [NUM_FWD_STAGES*DATA_W-1:0]   fwd_wdata_i,
    input  logic                               issue_i,
    input  logic [ADDR_W-1:0]                  issue_waddr_i,
    input  logic                               flush_i,
    input  logic                               cmpl_i,
    input  logic [ADDR_W-1:0]                  cmpl_waddr_i,
    input  logic [DATA_W-1:0]                  cmpl_wdata_i,
    output logic [NUM_RD_PORTS*DATA_W-1:0]     rdata_o,
    output logic                               stall_o,
    output logic [(2**ADDR_W)-1:0]             pending_o,
    output logic [CNT_W-1:0]                   stall_cnt_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [NumRegs-1:0]             pending_q, pending_d;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
    logic [NUM_RD_PORTS*DATA_W-1:0] rdata;
    logic                           raw_stall;
    logic                           waw_stall;
    logic                           issue_ok;

    // Per-port scratch used while walking the ports
    logic [ADDR_W-1:0]              port_addr;
    logic                           fwd_hit;
    logic                           fwd_hit_valid;
    logic                           port_cmpl_hit;

    // Resolve every operand and collect the per-port load-use / RAW-on-MDU hazards
    always_comb begin
        rdata         = '0;
        raw_stall     = 1'b0;
        port_addr     = '0;
        fwd_hit       = 1'b0;
        fwd_hit_valid = 1'b0;
        port_cmpl_hit = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            port_addr     = rd_addr_i[p*ADDR_W +: ADDR_W];
            fwd_hit       = 1'b0;
            fwd_hit_valid = 1'b0;
            port_cmpl_hit = cmpl_i && (cmpl_waddr_i == port_addr);

            // Lowest priority first, later assignments override
            rdata[p*DATA_W +: DATA_W] = rf_data_i[p*DATA_W +: DATA_W];
            if (port_cmpl_hit) begin
                rdata[p*DATA_W +: DATA_W] = cmpl_wdata_i;
            end
            // Youngest matching stage wins; older stages are ignored once a hit is found
            for (int s = 0; s < NUM_FWD_STAGES; s++) begin
                if (!fwd_hit && fwd_we_i[s] &&
                    (fwd_waddr_i[s*ADDR_W +: ADDR_W] == port_addr)) begin
                    fwd_hit                   = 1'b1;
                    fwd_hit_valid             = fwd_valid_i[s];
                    rdata[p*DATA_W +: DATA_W] = fwd_wdata_i[s*DATA_W +: DATA_W];
                end
            end
            if (port_addr == '0) begin
                rdata[p*DATA_W +: DATA_W] = '0;
            end

            if (rd_en_i[p] && (port_addr != '0)) begin
                if (fwd_hit && !fwd_hit_valid) begin
                    raw_stall = 1'b1;
                end
                if (pending_q[port_addr] && !port_cmpl_hit) begin
                    raw_stall = 1'b1;
                end
            end
        end
    end

    // WAW on a still-pending MDU destination, unless it retires this very cycle
    always_comb begin
        waw_stall = issue_i && (issue_waddr_i != '0) && pending_q[issue_waddr_i] &&
                    !(cmpl_i && (cmpl_waddr_i == issue_waddr_i));
    end

    // Output gating: reset silences everything, a squashed instruction never stalls
    always_comb begin
        stall_o  = !rst_i && !flush_i && (raw_stall || waw_stall);
        rdata_o  = rst_i ? '0 : rdata;
        issue_ok = issue_i && !stall_o && !flush_i && (issue_waddr_i != '0);
    end

    // Scoreboard next state: clear on completion, set on accepted issue (set wins)
    always_comb begin
        pending_d = pending_q;
        if (cmpl_i) begin
            pending_d[cmpl_waddr_i] = 1'b0;
        end
        if (issue_ok) begin
            pending_d[issue_waddr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pending_o   = pending_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Directed self-checking bench for id_fwd_scoreboard.
module tb_id_fwd_scoreboard;

    localparam int unsigned NP = 2;
    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rf_data;
    logic [NS-1:0]     fwd_we;
    logic [NS-1:0]     fwd_valid;
    logic [NS*AW-1:0]  fwd_waddr;
    logic [NS*DW-1:0]  fwd_wdata;
    logic              issue;
    logic [AW-1:0]     issue_waddr;
    logic              flush;
    logic              cmpl;
    logic [AW-1:0]     cmpl_waddr;
    logic [DW-1:0]     cmpl_wdata;
    logic [NP*DW-1:0]  rdata;
    logic              stall;
    logic [31:0]       pending;
    logic [CW-1:0]     stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_fwd_scoreboard #(
        .NUM_RD_PORTS   (NP),
        .NUM_FWD_STAGES (NS),
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CNT_W          (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_en_i       (rd_en),
        .rd_addr_i     (rd_addr),
        .rf_data_i     (rf_data),
        .fwd_we_i      (fwd_we),
        .fwd_valid_i   (fwd_valid),
        .fwd_waddr_i   (fwd_waddr),
        .fwd_wdata_i   (fwd_wdata),
        .issue_i       (issue),
        .issue_waddr_i (issue_waddr),
        .flush_i       (flush),
        .cmpl_i        (cmpl),
        .cmpl_waddr_i  (cmpl_waddr),
        .cmpl_wdata_i  (cmpl_wdata),
        .rdata_o       (rdata),
        .stall_o       (stall),
        .pending_o     (pending),
        .stall_cnt_o   (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        rd_en       = '0;
        rd_addr     = '0;
        rf_data     = {32'hB0B0_B0B0, 32'hA0A0_A0A0};
        fwd_we      = '0;
        fwd_valid   = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        issue       = 1'b0;
        issue_waddr = '0;
        flush       = 1'b0;
        cmpl        = 1'b0;
        cmpl_waddr  = '0;
        cmpl_wdata  = '0;
    endtask

    task automatic set_fwd(input int s, input logic we, input logic vld,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        fwd_we[s]              = we;
        fwd_valid[s]           = vld;
        fwd_waddr[s*AW +: AW]  = a;
        fwd_wdata[s*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rd_en[p]             = en;
        rd_addr[p*AW +: AW]  = a;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd4);
        settle();
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        step();
        step();
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        idle_inputs();

        // Priority: youngest stage wins, then older stage when young one is idle
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h11);
        set_fwd(2, 1'b1, 1'b1, 5'd5, 32'h33);
        set_fwd(1, 1'b1, 1'b1, 5'd6, 32'h22);
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd6);
        settle();
        check("prio_s0", 64'(rdata[0 +: DW]), 64'h11);
        check("prio_s1_port1", 64'(rdata[DW +: DW]), 64'h22);
        check("prio_stall", 64'(stall), 64'd0);
        fwd_we[0] = 1'b0;
        settle();
        check("prio_s2", 64'(rdata[0 +: DW]), 64'h33);
        set_rd(1, 1'b1, 5'd3);
        settle();
        check("rf_pass", 64'(rdata[DW +: DW]), 64'hB0B0_B0B0);
        step();
        idle_inputs();

        // Load-use
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h77);
        set_rd(1, 1'b1, 5'd7);
        settle();
        check("lu_stall", 64'(stall), 64'd1);
        check("lu_cnt0", 64'(stall_cnt), 64'd0);
        step();
        check("lu_cnt1", 64'(stall_cnt), 64'd1);
        rd_en[1] = 1'b0;
        settle();
        check("lu_unused", 64'(stall), 64'd0);
        step();
        check("lu_cnt_hold", 64'(stall_cnt), 64'd1);
        idle_inputs();

        // MDU RAW
        issue = 1'b1;
        issue_waddr = 5'd9;
        settle();
        check("mdu_issue_stall", 64'(stall), 64'd0);
        step();
        check("mdu_pending", 64'(pending), 64'h200);
        issue = 1'b0;
        set_rd(0, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mdu_raw_stall", 64'(stall), 64'd1);
            step();
        end
        check("mdu_cnt", 64'(stall_cnt), 64'd4);
        cmpl = 1'b1;
        cmpl_waddr = 5'd9;
        cmpl_wdata = 32'hDEAD;
        settle();
        check("mdu_bypass", 64'(rdata[0 +: DW]), 64'hDEAD);
        check("mdu_cmpl_stall", 64'(stall), 64'd0);
        step();
        idle_inputs();
        check("mdu_cleared", 64'(pending), 64'd0);
        check("mdu_cnt_hold", 64'(stall_cnt), 64'd4);

        // WAW and same-cycle set/clear
        issue = 1'b1;
        issue_waddr = 5'd4;
        step();
        check("waw_pending", 64'(pending), 64'h10);
        settle();
        check("waw_stall", 64'(stall), 64'd1);
        step();
        check("waw_held", 64'(pending), 64'h10);
        check("waw_cnt", 64'(stall_cnt), 64'd5);
        cmpl = 1'b1;
        cmpl_waddr = 5'd4;
        cmpl_wdata = 32'h4444;
        settle();
        check("setclr_stall", 64'(stall), 64'd0);
        step();
        check("setclr_pending", 64'(pending), 64'h10);
        issue = 1'b0;
        step();
        check("clr_pending", 64'(pending), 64'd0);
        cmpl_waddr = 5'd12;
        step();
        check("cmpl_nonpending", 64'(pending), 64'd0);
        idle_inputs();

        // Zero register and flush
        issue = 1'b1;
        issue_waddr = 5'd0;
        step();
        check("r0_pending", 64'(pending), 64'd0);
        issue = 1'b0;
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'h55);
        set_rd(0, 1'b1, 5'd0);
        settle();
        check("r0_rdata", 64'(rdata[0 +: DW]), 64'd0);
        idle_inputs();
        issue = 1'b1;
        issue_waddr = 5'd3;
        flush = 1'b1;
        step();
        check("flush_pending", 64'(pending), 64'd0);
        idle_inputs();
        flush = 1'b1;
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h77);
        set_rd(0, 1'b1, 5'd7);
        settle();
        check("flush_stall", 64'(stall), 64'd0);
        step();
        check("flush_cnt", 64'(stall_cnt), 64'd5);
        idle_inputs();

        // Reset mid-operation
        issue = 1'b1;
        issue_waddr = 5'd2;
        step();
        issue_waddr = 5'd6;
        step();
        issue = 1'b0;
        check("pre_rst_pending", 64'(pending), 64'h44);
        check("pre_rst_cnt", 64'(stall_cnt), 64'd5);
        rst = 1'b1;
        set_rd(0, 1'b1, 5'd2);
        set_rd(1, 1'b1, 5'd3);
        settle();
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        step();
        rst = 1'b0;
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_cnt", 64'(stall_cnt), 64'd0);
        settle();
        check("post_rst_rdata", 64'(rdata[DW +: DW]), 64'hB0B0_B0B0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_fwd_scoreboard.md
Name: id_fwd_scoreboard

Overview:
- Decode-stage operand resolver and hazard detector. Generalises the fixed two-port, two-stage RAW bypass to NUM_RD_PORTS read ports and NUM_FWD_STAGES forwarding stages.
- Adds a per-register scoreboard for long-latency writers (multiply/divide unit, MDU) and a load-use/not-ready stall output.
- Adds a saturating stall-cycle performance counter.
- Sits between the register-file read ports and the ID/EX pipeline register. It drives the stall into the hazard/pipeline-control logic.

Parameters:
- NUM_RD_PORTS, 2, number of operand read ports
- NUM_FWD_STAGES, 3, number of forwarding sources; index 0 = youngest (EX), ascending = older (MEM, WB)
- DATA_W, 32, data width
- ADDR_W, 5, register address width; 2**ADDR_W registers; register 0 is hard zero
- CNT_W, 32, stall counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- rd_en_i  in  NUM_RD_PORTS  port p is used by the instruction in ID
- rd_addr_i  in  NUM_RD_PORTS*ADDR_W  read address per port
- rf_data_i  in  NUM_RD_PORTS*DATA_W  raw register-file data per port
- fwd_we_i  in  NUM_FWD_STAGES  stage s writes a register
- fwd_valid_i  in  NUM_FWD_STAGES  stage s data is ready (0 for a load still in EX)
- fwd_waddr_i  in  NUM_FWD_STAGES*ADDR_W  stage s destination
- fwd_wdata_i  in  NUM_FWD_STAGES*DATA_W  stage s result
- issue_i  in  1  ID instruction is a long-latency (MDU) op
- issue_waddr_i  in  ADDR_W  MDU destination
- flush_i  in  1  ID instruction is squashed this cycle
- cmpl_i  in  1  MDU completes this cycle
- cmpl_waddr_i  in  ADDR_W  completing destination
- cmpl_wdata_i  in  DATA_W  completing result
- rdata_o  out  NUM_RD_PORTS*DATA_W  resolved operand per port
- stall_o  out  1  hold ID (and IF) this cycle
- pending_o  out  2**ADDR_W  scoreboard bit vector
- stall_cnt_o  out  CNT_W  stall-cycle count

Behaviour:
- Reset (rst_i=1 at a clk_i edge): pending clears to all 0 and stall_cnt clears to 0. While rst_i=1, rdata_o=0 and stall_o=0 combinationally.
- Operand resolution per port p (combinational, priority order):
  - addr==0: output 0.
  - Otherwise, the first stage s (0 upward) with fwd_we[s]=1 and waddr[s]==addr supplies fwd_wdata[s]. Older stages are ignored.
  - Otherwise, if cmpl_i=1 and cmpl_waddr==addr: output cmpl_wdata_i.
  - Otherwise: output rf_data_i.
- Stall conditions (combinational OR over ports with rd_en=1 and addr!=0):
  - The winning stage match has fwd_valid=0 (load-use).
  - pending[addr]=1 and not (cmpl_i=1 and cmpl_waddr==addr) (RAW on MDU result).
  - WAW: issue_i=1, issue_waddr!=0, and pending[issue_waddr]=1 without a same-cycle completion to that register.
  - flush_i=1 forces stall_o=0.
- Scoreboard update at each clk_i edge (rst_i=0):
  - Clear: cmpl_i=1 clears pending[cmpl_waddr].
  - Set: issue is accepted only when issue_i=1, stall_o=0, flush_i=0 and issue_waddr!=0. An accepted issue sets pending[issue_waddr].
  - If set and clear hit the same register in one cycle, set wins and the result is 1.
  - pending[0] is always 0.
  - Completion to a non-pending register is harmless and the bit stays 0.
- Long-latency ops present fwd_we=0 in all forwarding stages. The scoreboard alone tracks them.
- stall_cnt increments by 1 on each edge where stall_o=1 and saturates at all-ones.
- Latency: rdata_o and stall_o are zero-cycle (combinational from inputs and pending state). pending_o reflects registered state, updated 1 cycle after issue/cmpl.

Test Plan:
- Priority: stage0 and stage2 both write r5 (0x11 / 0x33), rd_addr0=5 -> rdata0=0x11, stall_o=0. Repeat with stage0 we=0 -> 0x33.
- Load-use: stage0 we=1, valid=0, waddr=7; port1 en=1 addr=7 -> stall_o=1 and stall_cnt goes 0->1. With rd_en1=0 -> stall_o=0.
- MDU RAW: issue r9 accepted; next cycle read r9 -> stall_o=1 for 3 cycles. On cmpl r9 data 0xDEAD -> rdata=0xDEAD, stall_o=0; then pending_o[9]=0.
- WAW and same-cycle set/clear: r4 pending, issue r4 without cmpl -> stall_o=1. Issue r4 together with cmpl r4 -> stall_o=0 and pending_o[4] stays 1.
- Zero register and flush: issue r0 -> pending_o stays 0, and reading r0 with stage0 writing r0=0x55 -> rdata=0. Issue r3 with flush_i=1 -> pending_o[3]=0.
- Reset mid-operation: r2 and r6 pending, stall_cnt=5, rst_i=1 for one edge -> pending_o=0, stall_cnt_o=0, and rdata_o=0 while rst_i=1.
